addsub_pipe: RTL and testbench
==============================

Name: addsub_pipe

Overview:
- Parametrised, pipelined successor to the 32-bit combinational add/subtract unit used by the MIPS ALU datapath.
- Splits the WIDTH-bit carry chain into STAGES equal slices, one slice per register stage.
- Adds a valid/ready handshake on both sides, a tag pass-through, and carry/overflow/zero/negative flags.
- Sits between the decode/issue logic and the writeback mux, and lets arithmetic run at higher clock rates.

Parameters:
- WIDTH, 32, operand and result width in bits.
- STAGES, 4, number of pipeline stages and carry-chain slices. Must be ≥1 and must divide WIDTH; any other value is an elaboration error.
- TAG_W, 5, width of the opaque tag carried alongside each operation (e.g. destination register index).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts the operation this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Sub  in  1  0: A+B, 1: A-B.
- in_tag  in  TAG_W  tag for the operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- S  out  WIDTH  result.
- C  out  1  carry-out of the full-width add. For Sub=1, C=1 means no borrow (A ≥ B unsigned).
- V  out  1  signed overflow.
- Z  out  1  S == 0.
- N  out  1  S[WIDTH-1].
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Arithmetic: the full operation is A + (Sub ? ~B : B) + Sub, modulo 2^WIDTH.
- Slicing: slice k (k = 0..STAGES-1) covers bits [k*W/S +: W/S]. Slice k is computed in stage k from the carry registered out of stage k-1. Stage 0 uses carry-in = Sub.
- Operand skew: the operand bits of later slices, Sub and the tag are delayed through the pipeline alongside the slices.
- Flags: C is the carry out of the top slice. V = carry into the MSB XOR carry out of the MSB. Z and N are evaluated on the final assembled S.
- Latency: exactly STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid, when there is no stall.
- Pipeline advance: advance = !out_valid | out_ready. This is a global enable and the same signal drives in_ready.
- When advance=0, every stage register and every output holds its value.
- Bubbles are not squeezed out; a bubble occupies its stage like a real operation.
- Valid bits: each stage carries a valid bit. A stage loads in_valid & in_ready when advance=1.
- Throughput: with out_ready held high, one result per cycle.
- Output stability: while out_valid=1 and out_ready=0, S, C, V, Z, N and out_tag stay stable.
- Result ordering: results emerge strictly in acceptance order. None are lost or duplicated.
- Reset: rst_n=0 clears all stage valid bits and all data registers asynchronously.
  - out_valid=0, S=0, C=V=Z=N=0, out_tag=0.
  - in_ready=1 during and after reset.
  - Operations in flight at reset are discarded. No result for them ever appears after rst_n rises.
- STAGES=1: a single registered add/sub with latency 1. The handshake rules are unchanged.
- in_valid=0 cycles enter as bubbles. A/B/Sub/in_tag are don't-care when in_valid=0.

Test Plan:
- WIDTH=32, STAGES=4. A=1, B=7, Sub=0 → after 4 cycles: S=0x00000008, C=0, V=0, Z=0, N=0, out_tag equals in_tag.
- A=1, B=7, Sub=1 → S=0xFFFFFFFA, C=0, V=0, Z=0, N=1.
- Carry across every slice boundary:
  - A=0xFFFFFFFF, B=1, Sub=0 → S=0, C=1, Z=1, V=0.
  - A=0x7FFFFFFF, B=1, Sub=0 → S=0x80000000, V=1, N=1, C=0.
  - A=0x80000000, B=1, Sub=1 → S=0x7FFFFFFF, V=1, C=1.
- Back-to-back 8 random ops, with out_ready driven low for 3 cycles mid-stream:
  - in_ready is low in exactly those cycles.
  - Outputs are held stable.
  - All 8 results match a reference model, in order, with matching tags.
- rst_n pulsed low with 3 ops in flight:
  - out_valid drops to 0 asynchronously.
  - After release, no result is produced until a new op is accepted; that op's result appears 4 cycles later.
- Re-run the scenarios at STAGES=1 and at STAGES=8 (WIDTH=32): identical results, with latency 1 and 8 respectively.

Source files
------------

// File: rtl/addsub_pipe_if.sv
// Handshake and data bundle for addsub_pipe. The slave side is the arithmetic unit; the master side is
// the issue logic plus the writeback consumer.
interface addsub_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             C;
  logic             V;
  logic             Z;
  logic             N;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, A, B, Sub, in_tag, out_ready,
    input  in_ready, out_valid, S, C, V, Z, N, out_tag
  );

  modport slave (
    input  in_valid, A, B, Sub, in_tag, out_ready,
    output in_ready, out_valid, S, C, V, Z, N, out_tag
  );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract: one WIDTH/STAGES carry slice per stage, with flags and a tag; latency STAGES.
// A single global enable (!out_valid | out_ready) stalls every stage together and drives in_ready.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  addsub_pipe_if.slave bus
);
  localparam int SW = (STAGES >= 1) ? WIDTH / STAGES : WIDTH;

  if (STAGES < 1) begin : g_bad_stages
    $error("addsub_pipe: STAGES must be at least 1");
  end else if (SW * STAGES != WIDTH) begin : g_bad_split
    $error("addsub_pipe: STAGES must divide WIDTH");
  end

  logic adv;
  logic out_vld;

  assign adv          = !out_vld || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SW;
    // operand bits from this slice upward; lower bits were consumed by earlier stages
    localparam int IW = WIDTH - LO;

    logic [IW-1:0]      a_in;
    logic [IW-1:0]      b_in;
    logic               sub_in;
    logic               vld_in;
    logic               cin;
    logic [TAG_W-1:0]   tag_in;
    logic [SW-1:0]      b_eff;
    logic [SW:0]        sum;
    logic [LO+SW-1:0]   s_d;

    logic               vld_q;
    logic               cy_q;
    logic [TAG_W-1:0]   tag_q;
    logic [LO+SW-1:0]   s_q;

    if (k == 0) begin : g_first
      assign a_in   = bus.A;
      assign b_in   = bus.B;
      assign sub_in = bus.Sub;
      assign tag_in = bus.in_tag;
      assign vld_in = bus.in_valid && adv;
      assign cin    = bus.Sub;
      assign s_d    = sum[SW-1:0];
    end else begin : g_next
      assign a_in   = g_stage[k-1].g_fwd.a_q;
      assign b_in   = g_stage[k-1].g_fwd.b_q;
      assign sub_in = g_stage[k-1].g_fwd.sub_q;
      assign tag_in = g_stage[k-1].tag_q;
      assign vld_in = g_stage[k-1].vld_q;
      assign cin    = g_stage[k-1].cy_q;
      assign s_d    = {sum[SW-1:0], g_stage[k-1].s_q};
    end

    assign b_eff = b_in[SW-1:0] ^ {SW{sub_in}};
    assign sum   = {1'b0, a_in[SW-1:0]} + {1'b0, b_eff} + {{SW{1'b0}}, cin};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        tag_q <= '0;
        s_q   <= '0;
      end else if (adv) begin
        vld_q <= vld_in;
        cy_q  <= sum[SW];
        tag_q <= tag_in;
        s_q   <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [IW-SW-1:0] a_q;
      logic [IW-SW-1:0] b_q;
      logic             sub_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          sub_q <= 1'b0;
        end else if (adv) begin
          a_q   <= a_in[IW-1:SW];
          b_q   <= b_in[IW-1:SW];
          sub_q <= sub_in;
        end
      end
    end else begin : g_last
      logic v_q;
      logic z_q;
      logic n_q;
      logic cm;

      // carry into the MSB recovered from the MSB sum bit
      assign cm = a_in[SW-1] ^ b_eff[SW-1] ^ sum[SW-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          z_q <= 1'b0;
          n_q <= 1'b0;
        end else if (adv) begin
          v_q <= cm ^ sum[SW];
          z_q <= (s_d == '0);
          n_q <= sum[SW-1];
        end
      end

      assign out_vld       = vld_q;
      assign bus.out_valid = vld_q;
      assign bus.S         = s_q;
      assign bus.C         = cy_q;
      assign bus.V         = v_q;
      assign bus.Z         = z_q;
      assign bus.N         = n_q;
      assign bus.out_tag   = tag_q;
    end
  end
endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe at STAGES = 1, 4 and 8 (WIDTH 32), one DUT selected at a time.
module tb_addsub_pipe;
  localparam int W  = 32;
  localparam int TW = 5;

  typedef struct packed {
    logic [W-1:0]  s;
    logic [3:0]    f;    // {C, V, Z, N}
    logic [TW-1:0] tag;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int sel;
  int lat;
  int n_checks = 0;
  int n_fail   = 0;

  logic          d_valid, d_sub, d_ready;
  logic [W-1:0]  d_a, d_b;
  logic [TW-1:0] d_tag;

  addsub_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus1 ();
  addsub_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus4 ();
  addsub_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus8 ();

  addsub_pipe #(.WIDTH(W), .STAGES(1), .TAG_W(TW)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  addsub_pipe #(.WIDTH(W), .STAGES(4), .TAG_W(TW)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  addsub_pipe #(.WIDTH(W), .STAGES(8), .TAG_W(TW)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  assign bus1.in_valid  = d_valid && (sel == 0);
  assign bus1.A         = d_a;
  assign bus1.B         = d_b;
  assign bus1.Sub       = d_sub;
  assign bus1.in_tag    = d_tag;
  assign bus1.out_ready = (sel == 0) ? d_ready : 1'b1;

  assign bus4.in_valid  = d_valid && (sel == 1);
  assign bus4.A         = d_a;
  assign bus4.B         = d_b;
  assign bus4.Sub       = d_sub;
  assign bus4.in_tag    = d_tag;
  assign bus4.out_ready = (sel == 1) ? d_ready : 1'b1;

  assign bus8.in_valid  = d_valid && (sel == 2);
  assign bus8.A         = d_a;
  assign bus8.B         = d_b;
  assign bus8.Sub       = d_sub;
  assign bus8.in_tag    = d_tag;
  assign bus8.out_ready = (sel == 2) ? d_ready : 1'b1;

  logic          o_in_ready, o_out_valid;
  logic [W-1:0]  o_s;
  logic [3:0]    o_f;
  logic [TW-1:0] o_tag;

  always_comb begin
    o_in_ready  = bus1.in_ready;
    o_out_valid = bus1.out_valid;
    o_s         = bus1.S;
    o_f         = {bus1.C, bus1.V, bus1.Z, bus1.N};
    o_tag       = bus1.out_tag;
    case (sel)
      1: begin
        o_in_ready  = bus4.in_ready;
        o_out_valid = bus4.out_valid;
        o_s         = bus4.S;
        o_f         = {bus4.C, bus4.V, bus4.Z, bus4.N};
        o_tag       = bus4.out_tag;
      end
      2: begin
        o_in_ready  = bus8.in_ready;
        o_out_valid = bus8.out_valid;
        o_s         = bus8.S;
        o_f         = {bus8.C, bus8.V, bus8.Z, bus8.N};
        o_tag       = bus8.out_tag;
      end
      default: ;
    endcase
  end

  // Reference: plain 33-bit add or subtract; subtraction borrow is the inverse of C.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic [TW-1:0] tag);
    logic [W:0] full;
    logic [W-1:0] s;
    logic c, v;
    res_t r;
    if (sub) begin
      full = {1'b0, a} - {1'b0, b};
      c    = ~full[W];
    end else begin
      full = {1'b0, a} + {1'b0, b};
      c    = full[W];
    end
    s = full[W-1:0];
    if (sub) v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    else     v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    r.s   = s;
    r.f   = {c, v, (s == '0), s[W-1]};
    r.tag = tag;
    return r;
  endfunction

  task automatic test_reset();
    d_valid = 1'b0;
    d_ready = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      n_checks++;
      if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_hs dut%0d: out_valid=%b in_ready=%b, want 0/1", i, o_out_valid, o_in_ready);
      end
      n_checks++;
      if ({o_s, o_f, o_tag} !== '0) begin
        n_fail++;
        $display("FAIL reset_data dut%0d: S=%h CVZN=%b tag=%h, want all zero", i, o_s, o_f, o_tag);
      end
    end
    sel = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0]  va [8];
    logic [W-1:0]  vb [8];
    logic          vs [8];
    logic [TW-1:0] vt;
    res_t exp;
    int cyc;
    va[0] = 32'h0000_0001; vb[0] = 32'h0000_0007; vs[0] = 1'b0;
    va[1] = 32'h0000_0001; vb[1] = 32'h0000_0007; vs[1] = 1'b1;
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'h0000_0001; vs[2] = 1'b0;
    va[3] = 32'h7FFF_FFFF; vb[3] = 32'h0000_0001; vs[3] = 1'b0;
    va[4] = 32'h8000_0000; vb[4] = 32'h0000_0001; vs[4] = 1'b1;
    for (int i = 5; i < 8; i++) begin
      va[i] = $urandom; vb[i] = $urandom; vs[i] = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      vt = TW'($urandom);
      exp = model(va[i], vb[i], vs[i], vt);
      @(negedge clk);
      d_valid = 1'b1; d_ready = 1'b1;
      d_a = va[i]; d_b = vb[i]; d_sub = vs[i]; d_tag = vt;
      @(negedge clk);
      d_valid = 1'b0;
      cyc = 1;
      while (!o_out_valid && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      n_checks++;
      if (cyc != lat) begin
        n_fail++;
        $display("FAIL dir_latency[%0d] lat=%0d: took %0d cycles, want %0d", i, lat, cyc, lat);
      end
      n_checks++;
      if (o_s !== exp.s) begin
        n_fail++;
        $display("FAIL dir_S[%0d] lat=%0d: got %h want %h", i, lat, o_s, exp.s);
      end
      n_checks++;
      if (o_f !== exp.f) begin
        n_fail++;
        $display("FAIL dir_CVZN[%0d] lat=%0d: got %b want %b", i, lat, o_f, exp.f);
      end
      n_checks++;
      if (o_tag !== exp.tag) begin
        n_fail++;
        $display("FAIL dir_tag[%0d] lat=%0d: got %h want %h", i, lat, o_tag, exp.tag);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]  ra [8];
    logic [W-1:0]  rb [8];
    logic          rs [8];
    logic [TW-1:0] rt [8];
    res_t q[$];
    res_t exp;
    int sent = 0;
    int got  = 0;
    int t    = 0;
    logic stall;
    for (int i = 0; i < 8; i++) begin
      ra[i] = $urandom; rb[i] = $urandom; rs[i] = 1'($urandom); rt[i] = TW'($urandom);
    end
    while (got < 8 && t < 80) begin
      @(negedge clk);
      stall   = (t >= lat + 1) && (t <= lat + 3);
      d_ready = !stall;
      d_valid = (sent < 8);
      if (sent < 8) begin
        d_a = ra[sent]; d_b = rb[sent]; d_sub = rs[sent]; d_tag = rt[sent];
      end
      #1;
      n_checks++;
      if (o_in_ready !== !stall) begin
        n_fail++;
        $display("FAIL b2b_in_ready lat=%0d t=%0d: got %b want %b", lat, t, o_in_ready, !stall);
      end
      if (o_out_valid) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_spurious lat=%0d t=%0d: out_valid=1, want no pending result", lat, t);
        end else begin
          exp = q[0];
          if ({o_s, o_f, o_tag} !== exp) begin
            n_fail++;
            $display("FAIL b2b_result[%0d] lat=%0d t=%0d: got S=%h CVZN=%b tag=%h want S=%h CVZN=%b tag=%h",
                     got, lat, t, o_s, o_f, o_tag, exp.s, exp.f, exp.tag);
          end
          if (!stall) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (d_valid && !stall) begin
        q.push_back(model(ra[sent], rb[sent], rs[sent], rt[sent]));
        sent++;
      end
      t++;
    end
    d_valid = 1'b0;
    d_ready = 1'b1;
    n_checks++;
    if (got != 8 || q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count lat=%0d: got %0d results (%0d pending), want 8 (0 pending)", lat, got, q.size());
    end
  endtask

  task automatic test_reset_in_flight();
    res_t exp;
    int cyc;
    int spurious = 0;
    d_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      d_valid = 1'b1; d_a = $urandom; d_b = $urandom; d_sub = 1'($urandom); d_tag = TW'($urandom);
    end
    @(negedge clk);
    d_valid = 1'b0;
    cyc = 0;
    while (!o_out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (o_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_fill lat=%0d: out_valid=%b after %0d cycles, want 1", lat, o_out_valid, cyc);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_async lat=%0d: out_valid=%b in_ready=%b, want 0/1", lat, o_out_valid, o_in_ready);
    end
    n_checks++;
    if ({o_s, o_f, o_tag} !== '0) begin
      n_fail++;
      $display("FAIL rst_async_data lat=%0d: S=%h CVZN=%b tag=%h, want all zero", lat, o_s, o_f, o_tag);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    d_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_out_valid) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL rst_discard lat=%0d: %0d cycles with out_valid after reset, want 0", lat, spurious);
    end
    @(negedge clk);
    d_valid = 1'b1; d_a = $urandom; d_b = $urandom; d_sub = 1'($urandom); d_tag = TW'($urandom);
    exp = model(d_a, d_b, d_sub, d_tag);
    @(negedge clk);
    d_valid = 1'b0;
    cyc = 1;
    while (!o_out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc != lat) begin
      n_fail++;
      $display("FAIL rst_new_latency lat=%0d: took %0d cycles, want %0d", lat, cyc, lat);
    end
    n_checks++;
    if ({o_s, o_f, o_tag} !== exp) begin
      n_fail++;
      $display("FAIL rst_new_result lat=%0d: got S=%h CVZN=%b tag=%h want S=%h CVZN=%b tag=%h",
               lat, o_s, o_f, o_tag, exp.s, exp.f, exp.tag);
    end
    @(negedge clk);
  endtask

  initial begin
    d_valid = 1'b0; d_ready = 1'b1; d_sub = 1'b0;
    d_a = '0; d_b = '0; d_tag = '0;
    sel = 0; lat = 1;
    test_reset();
    for (int i = 0; i < 3; i++) begin
      sel = i;
      lat = (i == 0) ? 1 : (i == 1) ? 4 : 8;
      @(negedge clk);
      test_directed();
      test_back_to_back();
      test_reset_in_flight();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end
endmodule
